// File: rtl/nco_tdm_if.sv
// Config, modulation and sample bus of the time-multiplexed NCO.
// Latency: none, wiring only.
// Backpressure: none; the NCO is stalled only through its clken input.
interface nco_tdm_if #(
    parameter int NCH   = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                    cfg_we;
    logic                    cfg_sel;
    logic [CW-1:0]           cfg_addr;
    logic [ACC_W-1:0]        cfg_data;
    logic                    sync_i;
    logic [ACC_W-1:0]        freq_mod_i;
    logic [ACC_W-1:0]        phase_mod_i;
    logic [CW-1:0]           slot_o;
    logic                    out_valid;
    logic [CW-1:0]           out_chan;
    logic signed [OUT_W-1:0] fsin_o;
    logic signed [OUT_W-1:0] fcos_o;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_data, sync_i, freq_mod_i, phase_mod_i,
        input  slot_o, out_valid, out_chan, fsin_o, fcos_o
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_data, sync_i, freq_mod_i, phase_mod_i,
        output slot_o, out_valid, out_chan, fsin_o, fcos_o
    );
endinterface

// File: rtl/nco_tdm.sv
// NCH-channel round-robin NCO with per-slot freq/phase modulation and quarter-wave sin/cos.
// Latency: 4 clken cycles from slot to sample (phase, address, ROM, sign).
// Backpressure: none; clken low freezes every register including the outputs.
module nco_tdm #(
    parameter int NCH    = 4,
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clken,
    nco_tdm_if.slave  bus
);
    localparam int  CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int  LUT_N = 1 << LUT_AW;
    localparam int  TOP_W = LUT_AW + 2;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((1 << (OUT_W - 1)) - 1);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    // Half-step sampled quarter wave: entry k mirrors exactly onto entry ~k.
    logic [OUT_W-2:0] rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam real ANG = (real'(k) + 0.5) * PI / real'(2 * LUT_N);
        localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
        assign rom[k] = VAL[OUT_W-2:0];
    end

    logic [ACC_W-1:0]        acc  [NCH];
    logic [ACC_W-1:0]        inc  [NCH];
    logic [ACC_W-1:0]        poff [NCH];
    logic [CW-1:0]           slot;
    logic [ACC_W-1:0]        ph_nxt;
    logic [TOP_W-1:0]        ph_top_nxt;
    logic [TOP_W-1:0]        ph_top;
    logic                    addr_ok;
    logic [3:0]              vld;
    logic [CW-1:0]           chan1, chan2, chan3, chan4;
    logic [LUT_AW-1:0]       addr_s, addr_c;
    logic                    neg_s1, neg_c1, neg_s2, neg_c2;
    logic [OUT_W-2:0]        mag_s, mag_c;
    logic signed [OUT_W-1:0] mag_s_ext, mag_c_ext;
    logic signed [OUT_W-1:0] fsin_q, fcos_q;
    logic [1:0]              quad;
    logic [LUT_AW-1:0]       frac;

    assign ph_nxt     = acc[slot] + poff[slot] + bus.phase_mod_i;
    assign ph_top_nxt = TOP_W'(ph_nxt >> (ACC_W - TOP_W));
    assign addr_ok    = 32'(bus.cfg_addr) < 32'(NCH);
    assign quad       = ph_top[TOP_W-1 -: 2];
    assign frac       = ph_top[LUT_AW-1:0];
    assign mag_s_ext  = $signed({1'b0, mag_s});
    assign mag_c_ext  = $signed({1'b0, mag_c});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                inc[i]  <= '0;
                poff[i] <= '0;
            end
            slot   <= '0;
            ph_top <= '0;
            vld    <= '0;
            chan1  <= '0;
            chan2  <= '0;
            chan3  <= '0;
            chan4  <= '0;
            addr_s <= '0;
            addr_c <= '0;
            neg_s1 <= 1'b0;
            neg_c1 <= 1'b0;
            neg_s2 <= 1'b0;
            neg_c2 <= 1'b0;
            mag_s  <= '0;
            mag_c  <= '0;
            fsin_q <= '0;
            fcos_q <= '0;
        end else if (clken) begin
            slot <= (slot == LAST) ? '0 : slot + CW'(1);
            // Sync wins over the served channel's update; ph above still sees the old acc.
            for (int i = 0; i < NCH; i++) begin
                if (bus.sync_i)
                    acc[i] <= '0;
                else if (CW'(i) == slot)
                    acc[i] <= acc[i] + inc[i] + bus.freq_mod_i;
            end
            if (bus.cfg_we && addr_ok) begin
                if (bus.cfg_sel)
                    poff[bus.cfg_addr] <= bus.cfg_data;
                else
                    inc[bus.cfg_addr] <= bus.cfg_data;
            end

            ph_top <= ph_top_nxt;
            chan1  <= slot;
            vld    <= {vld[2:0], 1'b1};

            // Odd quadrants read the mirrored address; cos is sin one quadrant on.
            addr_s <= quad[0] ? ~frac : frac;
            neg_s1 <= quad[1];
            addr_c <= quad[0] ? frac : ~frac;
            neg_c1 <= quad[1] ^ quad[0];
            chan2  <= chan1;

            mag_s  <= rom[addr_s];
            mag_c  <= rom[addr_c];
            neg_s2 <= neg_s1;
            neg_c2 <= neg_c1;
            chan3  <= chan2;

            fsin_q <= neg_s2 ? -mag_s_ext : mag_s_ext;
            fcos_q <= neg_c2 ? -mag_c_ext : mag_c_ext;
            chan4  <= chan3;
        end
    end

    assign bus.slot_o    = slot;
    assign bus.out_valid = vld[3];
    assign bus.out_chan  = chan4;
    assign bus.fsin_o    = fsin_q;
    assign bus.fcos_o    = fcos_q;
endmodule

// File: tb/tb_nco_tdm.sv
// Bench for nco_tdm: reference model pushes expected samples per slot, outputs are popped and compared.
module tb_nco_tdm;
    typedef struct {
        int chan;
        int s;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clken;

    nco_tdm_if #(.NCH(4), .ACC_W(32), .OUT_W(16)) bus();

    nco_tdm #(.NCH(4), .ACC_W(32), .LUT_AW(10), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tbl [1024];
    logic [31:0] m_acc [4];
    logic [31:0] m_inc [4];
    logic [31:0] m_poff [4];
    int          m_slot;
    int          m_cnt;
    bit          freeze0;
    exp_t        sb [$];
    exp_t        last;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lut(input logic [31:0] ph, input bit cosine);
        logic [1:0] q;
        logic [9:0] a;
        int         m;
        q = ph[31:30] + {1'b0, cosine};
        a = ph[29:20];
        if (q[0]) a = ~a;
        m = tbl[a];
        return q[1] ? -m : m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_acc[i]  = '0;
            m_inc[i]  = '0;
            m_poff[i] = '0;
        end
        m_slot = 0;
        m_cnt  = 0;
        sb.delete();
        last = '{chan: 0, s: 0, c: 0};
    endtask

    task automatic tick();
        exp_t        e;
        logic [31:0] ph;
        bit          was_en;
        if (freeze0)
            bus.freq_mod_i = (m_slot == 0) ? (32'd0 - m_inc[0]) : 32'd0;
        was_en = clken;
        if (clken) begin
            ph  = m_acc[m_slot] + m_poff[m_slot] + bus.phase_mod_i;
            e.chan = m_slot;
            e.s    = lut(ph, 1'b0);
            e.c    = lut(ph, 1'b1);
            sb.push_back(e);
            if (bus.sync_i) begin
                for (int i = 0; i < 4; i++) m_acc[i] = '0;
            end else begin
                m_acc[m_slot] = m_acc[m_slot] + m_inc[m_slot] + bus.freq_mod_i;
            end
            if (bus.cfg_we) begin
                if (bus.cfg_sel) m_poff[bus.cfg_addr] = bus.cfg_data;
                else             m_inc[bus.cfg_addr]  = bus.cfg_data;
            end
            m_slot = (m_slot == 3) ? 0 : m_slot + 1;
            if (m_cnt < 4) m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("slot", int'(bus.slot_o), m_slot);
        chk("valid", int'(bus.out_valid), int'(m_cnt >= 4));
        if (m_cnt >= 4) begin
            if (was_en) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else                last = sb.pop_front();
            end
            chk("chan", int'(bus.out_chan), last.chan);
            chk("sin", int'(bus.fsin_o), last.s);
            chk("cos", int'(bus.fcos_o), last.c);
        end
    endtask

    task automatic cfg(input bit sel, input int addr, input logic [31:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_addr = 2'(addr);
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic wait_chan(input int c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            tick();
            if (bus.out_valid && int'(bus.out_chan) == c) ok = 1'b1;
        end
        if (!ok) chk("wait_chan_timeout", 0, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_slot"}, int'(bus.slot_o), 0);
        chk({tag, "_chan"}, int'(bus.out_chan), 0);
        chk({tag, "_sin"}, int'(bus.fsin_o), 0);
        chk({tag, "_cos"}, int'(bus.fcos_o), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [4];
        int v   [4];
        int k;
        seq = '{25, 32767, -25, -32767};
        for (int i = 0; i < 1024; i++)
            tbl[i] = $rtoi(32767.0 * $sin((real'(i) + 0.5) * 3.14159265358979323846 / 2048.0) + 0.5);

        reset = 1'b1;
        clken = 1'b1;
        freeze0 = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_sel = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.sync_i = 1'b0;
        bus.freq_mod_i = '0;
        bus.phase_mod_i = '0;
        model_clear();

        // 1: reset, zero config
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;
        repeat (12) tick();
        chk("t1_sin", int'(bus.fsin_o), 25);
        chk("t1_cos", int'(bus.fcos_o), 32767);

        // 2: ch0 quarter-turn increment
        cfg(1'b0, 0, 32'h4000_0000);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            wait_chan(0);
            v[i] = int'(bus.fsin_o);
        end
        k = -1;
        for (int i = 0; i < 4; i++) if (seq[i] == v[0]) k = i;
        if (k < 0) chk("t2_start", v[0], 25);
        else for (int i = 1; i < 4; i++) chk("t2_seq", v[i], seq[(k + i) % 4]);

        // 3: ch1 half-turn offset
        cfg(1'b1, 1, 32'h8000_0000);
        repeat (4) tick();
        wait_chan(1);
        chk("t3_sin", int'(bus.fsin_o), -25);
        chk("t3_cos", int'(bus.fcos_o), -32767);

        // 4: freeze
        clken = 1'b0;
        repeat (5) tick();
        clken = 1'b1;
        repeat (6) tick();

        // 5: sync restart
        cfg(1'b0, 0, 32'h1000_0000);
        repeat (10) tick();
        bus.sync_i = 1'b1;
        tick();
        bus.sync_i = 1'b0;
        repeat (3) tick();
        wait_chan(0);
        chk("t5_sin0", int'(bus.fsin_o), 25);
        chk("t5_cos0", int'(bus.fcos_o), 32767);
        wait_chan(1);
        chk("t5_sin1", int'(bus.fsin_o), -25);

        // random mix of everything
        for (int i = 0; i < 60; i++) begin
            clken           = ($urandom_range(0, 7) != 0);
            bus.cfg_we      = ($urandom_range(0, 4) == 0);
            bus.cfg_sel     = 1'($urandom_range(0, 1));
            bus.cfg_addr    = 2'($urandom_range(0, 3));
            bus.cfg_data    = $urandom;
            bus.sync_i      = ($urandom_range(0, 15) == 0);
            bus.freq_mod_i  = $urandom;
            bus.phase_mod_i = $urandom;
            tick();
        end
        clken = 1'b1;
        bus.cfg_we = 1'b0;
        bus.sync_i = 1'b0;
        bus.freq_mod_i = '0;
        bus.phase_mod_i = '0;
        repeat (4) tick();

        // 6: asynchronous reset mid-stream, refill, then freq-mod freeze of ch0
        #3;
        reset = 1'b1;
        #1;
        chk_reset_state("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        repeat (6) tick();
        cfg(1'b0, 0, 32'h1000_0000);
        repeat (8) tick();
        freeze0 = 1'b1;
        repeat (8) tick();
        wait_chan(0);
        v[0] = int'(bus.fsin_o);
        wait_chan(0);
        chk("t6_freeze", int'(bus.fsin_o), v[0]);
        freeze0 = 1'b0;
        bus.freq_mod_i = '0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
